// File: rtl/aes_pkg.sv
// Shared AES constants: block geometry, engine state encoding and the
// forward/inverse S-box ROM contents.
package aes_pkg;

  localparam int AES_NB  = 4;
  localparam int STATE_W = 32 * AES_NB;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Rows are written in natural byte order, so entry b sits at packed index ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Valid/ready handshake bundle between the SubBytes engine, its producer
// and the downstream ShiftRows stage.
interface sub_bytes_iter_if;
  import aes_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] Input;
  logic               Decrypt;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] Output;

  modport master (
    output in_valid, Input, Decrypt, out_ready,
    input  in_ready, out_valid, Output
  );

  modport slave (
    input  in_valid, Input, Decrypt, out_ready,
    output in_ready, out_valid, Output
  );

endinterface

// File: rtl/aes_sbox.sv
// Single-byte AES S-box with forward/inverse select, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  input  logic       decrypt,
  output logic [7:0] out_byte
);

  assign out_byte = decrypt ? INV_SBOX[~in_byte] : SBOX[~in_byte];

endmodule

// File: rtl/sub_bytes_iter.sv
// Column-serial SubBytes/InvSubBytes: one 32-bit column per cycle through
// four shared S-boxes, four cycles per block, registered result.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int NCOL = AES_NB
)
(
  input  logic            clk,
  input  logic            rst,
  sub_bytes_iter_if.slave bus
);

  localparam int CW = $clog2(NCOL);

  state_t             state;
  logic [CW-1:0]      col_cnt;
  logic [STATE_W-1:0] data_q;
  logic               dec_q;
  logic               out_valid_q;
  logic               in_ready;
  logic               accept;
  logic [31:0]        col_word;
  logic [31:0]        sub_word;

  assign in_ready      = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept        = bus.in_valid & in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.Output    = data_q;

  // Column 0 is the most significant word of the state.
  always_comb begin
    col_word = '0;
    for (int c = 0; c < NCOL; c++) begin
      if (col_cnt == c[CW-1:0]) begin
        col_word = data_q[STATE_W-1-32*c -: 32];
      end
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (col_word[31-8*i -: 8]),
      .decrypt  (dec_q),
      .out_byte (sub_word[31-8*i -: 8])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      col_cnt     <= '0;
      data_q      <= '0;
      dec_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            data_q  <= bus.Input;
            dec_q   <= bus.Decrypt;
            col_cnt <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          for (int c = 0; c < NCOL; c++) begin
            if (col_cnt == c[CW-1:0]) begin
              data_q[STATE_W-1-32*c -: 32] <= sub_word;
            end
          end
          if (col_cnt == CW'(NCOL - 1)) begin
            col_cnt     <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end
        DONE: begin
          // A waiting block is taken in the same edge the result is consumed.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              data_q  <= bus.Input;
              dec_q   <= bus.Decrypt;
              col_cnt <= '0;
              state   <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Self-checking bench for sub_bytes_iter: table-driven blocks plus directed
// backpressure, back-to-back and mid-block reset sequences.
module tb_sub_bytes_iter;
  import aes_pkg::*;

  typedef struct {
    logic [127:0] din;
    logic         dec;
    logic [127:0] expected;
  } vec_t;

  localparam logic [127:0] FWD_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FWD_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic clk = 1'b0;
  logic rst;
  int   nChecks = 0;
  int   nErrors = 0;
  vec_t vecs [7];

  sub_bytes_iter_if bus ();

  sub_bytes_iter #(.NCOL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid until an accept edge has passed (bounded wait).
  task automatic applyStimulus(input logic [127:0] din, input logic dec);
    logic rdy;
    bit   ok;
    ok = 1'b0;
    bus.Input    = din;
    bus.Decrypt  = dec;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      rdy = bus.in_ready;
      tick();
      ok = rdy;
    end
    checkOutput("accept", 128'(ok), 128'd1);
    bus.in_valid = 1'b0;
  endtask

  // Inputs are scrambled during BUSY to prove they are sampled only on accept.
  task automatic runVector(input vec_t v, input string name);
    bus.out_ready = 1'b1;
    applyStimulus(v.din, v.dec);
    bus.Input   = ~v.din;
    bus.Decrypt = ~v.dec;
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput({name, " busy out_valid"}, 128'(bus.out_valid), 128'd0);
      checkOutput({name, " busy in_ready"}, 128'(bus.in_ready), 128'd0);
    end
    tick();
    checkOutput({name, " done out_valid"}, 128'(bus.out_valid), 128'd1);
    checkOutput({name, " data"}, bus.Output, v.expected);
    tick();
    checkOutput({name, " idle out_valid"}, 128'(bus.out_valid), 128'd0);
    checkOutput({name, " idle in_ready"}, 128'(bus.in_ready), 128'd1);
  endtask

  initial begin
    vecs[0] = '{FWD_IN, 1'b0, FWD_OUT};
    vecs[1] = '{FWD_OUT, 1'b1, FWD_IN};
    vecs[2] = '{128'h01000000_00000000_00000000_00000053, 1'b0,
                128'h7c636363_63636363_63636363_636363ed};
    vecs[3] = '{{16{8'h00}}, 1'b0, {16{8'h63}}};
    vecs[4] = '{{16{8'hff}}, 1'b0, {16{8'h16}}};
    vecs[5] = '{{16{8'h63}}, 1'b1, {16{8'h00}}};
    vecs[6] = '{{16{8'h16}}, 1'b1, {16{8'hff}}};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.Input     = '0;
    bus.Decrypt   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    checkOutput("reset out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("reset Output", bus.Output, 128'd0);
    checkOutput("reset in_ready", 128'(bus.in_ready), 128'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result must hold while the producer keeps wiggling inputs.
    bus.out_ready = 1'b0;
    applyStimulus(FWD_IN, 1'b0);
    for (int k = 1; k < 5; k++) tick();
    for (int k = 0; k < 10; k++) begin
      checkOutput("hold out_valid", 128'(bus.out_valid), 128'd1);
      checkOutput("hold Output", bus.Output, FWD_OUT);
      checkOutput("hold in_ready", 128'(bus.in_ready), 128'd0);
      bus.Input    = {$urandom, $urandom, $urandom, $urandom};
      bus.Decrypt  = ~bus.Decrypt;
      bus.in_valid = 1'b1;
      tick();
    end
    checkOutput("hold final Output", bus.Output, FWD_OUT);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("release in_ready", 128'(bus.in_ready), 128'd1);
    tick();
    checkOutput("release out_valid", 128'(bus.out_valid), 128'd0);
    bus.out_ready = 1'b0;
    #1;
    checkOutput("release idle in_ready", 128'(bus.in_ready), 128'd1);
    tick();

    // Back-to-back: second block accepted on the edge the first is consumed.
    bus.out_ready = 1'b1;
    applyStimulus({16{8'h00}}, 1'b0);
    bus.Input    = {16{8'hff}};
    bus.Decrypt  = 1'b0;
    bus.in_valid = 1'b1;
    for (int k = 1; k < 4; k++) tick();
    tick();
    checkOutput("b2b first out_valid", 128'(bus.out_valid), 128'd1);
    checkOutput("b2b first Output", bus.Output, {16{8'h63}});
    checkOutput("b2b first in_ready", 128'(bus.in_ready), 128'd1);
    tick();
    checkOutput("b2b gap out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("b2b gap in_ready", 128'(bus.in_ready), 128'd0);
    for (int k = 1; k < 4; k++) begin
      tick();
      checkOutput("b2b busy out_valid", 128'(bus.out_valid), 128'd0);
    end
    tick();
    checkOutput("b2b second out_valid", 128'(bus.out_valid), 128'd1);
    checkOutput("b2b second Output", bus.Output, {16{8'h16}});
    bus.in_valid = 1'b0;
    tick();
    checkOutput("b2b idle out_valid", 128'(bus.out_valid), 128'd0);

    // Reset during the second BUSY cycle discards the partial block.
    applyStimulus(FWD_IN, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("midrst Output", bus.Output, 128'd0);
    checkOutput("midrst in_ready", 128'(bus.in_ready), 128'd1);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput("midrst no stale out_valid", 128'(bus.out_valid), 128'd0);
      checkOutput("midrst no stale Output", bus.Output, 128'd0);
    end
    checkOutput("midrst in_ready after", 128'(bus.in_ready), 128'd1);
    runVector(vecs[2], "post-reset");

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
